// File: rtl/nand_bus_arbiter_if.sv
`default_nettype none
// ============================================================
// nand_bus_arbiter_if : request/grant and NAND control bundle
// Rev 1.0
// ============================================================
interface nand_bus_arbiter_if;
   logic       req0, req1;
   logic       gnt0, gnt1;
   logic       m0_cle, m0_ale, m0_wen, m0_ren, m0_io_oe;
   logic [7:0] m0_io_out;
   logic       m1_cle, m1_ale, m1_wen, m1_ren, m1_io_oe;
   logic [7:0] m1_io_out;
   logic [7:0] io_in;
   logic       rb_sync;
   logic       F_CLE, F_ALE, F_WEN, F_REN, F_RB;
   logic       timeout_err;

   modport slave (
      input  req0, req1,
      input  m0_cle, m0_ale, m0_wen, m0_ren, m0_io_oe, m0_io_out,
      input  m1_cle, m1_ale, m1_wen, m1_ren, m1_io_oe, m1_io_out,
      input  F_RB,
      output gnt0, gnt1, io_in, rb_sync,
      output F_CLE, F_ALE, F_WEN, F_REN, timeout_err
   );

   modport master (
      output req0, req1,
      output m0_cle, m0_ale, m0_wen, m0_ren, m0_io_oe, m0_io_out,
      output m1_cle, m1_ale, m1_wen, m1_ren, m1_io_oe, m1_io_out,
      output F_RB,
      input  gnt0, gnt1, io_in, rb_sync,
      input  F_CLE, F_ALE, F_WEN, F_REN, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/nand_bus_arbiter.sv
`default_nettype none
// ============================================================
// nand_bus_arbiter : two-master round-robin NAND bus sharing
// Rev 1.0
// ============================================================
module nand_bus_arbiter #(
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 4096,
   parameter int CNT_W      = 13
) (
   input  wire logic         clk,
   input  wire logic         rst,
   nand_bus_arbiter_if.slave bus,
   inout  wire [7:0]         F_IO
);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_wd_last  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT0 = 2'd1,
      S_GRANT1 = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_rb_meta, r_rb_sync;
   logic             r_gnt0, r_gnt1;
   logic             r_last_owner;
   logic             r_lock0, r_lock1;
   logic             r_timeout_err;
   logic [CNT_W-1:0] r_wd_cnt;
   logic [GAP_W-1:0] r_gap_cnt;

   logic w_elig0, w_elig1, w_pick1, w_owner_req, w_wd_hit;
   logic w_cle, w_ale, w_wen, w_ren, w_io_oe;
   logic [7:0] w_io_out;

   assign w_elig0     = bus.req0 & ~r_lock0;
   assign w_elig1     = bus.req1 & ~r_lock1;
   // On a tie the master that did not own the bus last wins
   assign w_pick1     = w_elig1 & (~w_elig0 | ~r_last_owner);
   assign w_owner_req = (r_state == S_GRANT1) ? bus.req1 : bus.req0;
   assign w_wd_hit    = r_rb_sync & (r_wd_cnt == c_wd_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_rb_meta     <= 1'b0;
         r_rb_sync     <= 1'b0;
         r_gnt0        <= 1'b0;
         r_gnt1        <= 1'b0;
         r_last_owner  <= 1'b1;
         r_lock0       <= 1'b0;
         r_lock1       <= 1'b0;
         r_timeout_err <= 1'b0;
         r_wd_cnt      <= '0;
         r_gap_cnt     <= '0;
      end else begin
         r_rb_meta     <= bus.F_RB;
         r_rb_sync     <= r_rb_meta;
         r_timeout_err <= 1'b0;
         if (!bus.req0) r_lock0 <= 1'b0;
         if (!bus.req1) r_lock1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_rb_sync && (w_elig0 || w_elig1)) begin
                  r_wd_cnt <= '0;
                  if (w_pick1) begin
                     r_state <= S_GRANT1;
                     r_gnt1  <= 1'b1;
                  end else begin
                     r_state <= S_GRANT0;
                     r_gnt0  <= 1'b1;
                  end
               end
            end
            S_GRANT0, S_GRANT1: begin
               if (!w_owner_req || w_wd_hit) begin
                  r_state      <= S_GAP;
                  r_gnt0       <= 1'b0;
                  r_gnt1       <= 1'b0;
                  r_gap_cnt    <= '0;
                  r_last_owner <= (r_state == S_GRANT1);
                  // A plain release wins over a simultaneous watchdog hit
                  if (w_owner_req) begin
                     r_timeout_err <= 1'b1;
                     if (r_state == S_GRANT1) r_lock1 <= 1'b1;
                     else                     r_lock0 <= 1'b1;
                  end
               end else if (r_rb_sync) begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == c_gap_last) r_state   <= S_IDLE;
               else                         r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_cle    = 1'b0;
      w_ale    = 1'b0;
      w_wen    = 1'b1;
      w_ren    = 1'b1;
      w_io_oe  = 1'b0;
      w_io_out = 8'h00;
      case (r_state)
         S_GRANT0: begin
            w_cle    = bus.m0_cle;
            w_ale    = bus.m0_ale;
            w_wen    = bus.m0_wen;
            w_ren    = bus.m0_ren;
            w_io_oe  = bus.m0_io_oe;
            w_io_out = bus.m0_io_out;
         end
         S_GRANT1: begin
            w_cle    = bus.m1_cle;
            w_ale    = bus.m1_ale;
            w_wen    = bus.m1_wen;
            w_ren    = bus.m1_ren;
            w_io_oe  = bus.m1_io_oe;
            w_io_out = bus.m1_io_out;
         end
         default: ;
      endcase
   end

   assign F_IO            = w_io_oe ? w_io_out : 8'hzz;
   assign bus.io_in       = F_IO;
   assign bus.F_CLE       = w_cle;
   assign bus.F_ALE       = w_ale;
   assign bus.F_WEN       = w_wen;
   assign bus.F_REN       = w_ren;
   assign bus.gnt0        = r_gnt0;
   assign bus.gnt1        = r_gnt1;
   assign bus.rb_sync     = r_rb_sync;
   assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire
